// File: rtl/timer_down60.sv
// timer_down60 -- MM:SS BCD countdown timer (00:00 .. 59:59).
//
// Each field is a mod-60 BCD down-counter with a borrow chain
// SL -> SH -> ML -> MH. An internal prescaler derives the one-second tick.
// A STOP/RUN/ALARM state machine sequences the count. Reaching 00:00 while
// running raises ALARM. ALARM clears itself after ALARM_SEC seconds, or
// earlier when acknowledged with START or STOP.
//
// Ports:
//   CLK                 system clock, all state updates on posedge
//   RST                 asynchronous active-high reset
//   CLR                 synchronous load of LD_* (saturated to BCD), forces STOP
//   START               level request to run (ignored at 00:00)
//   STOP                level request to halt / acknowledge alarm
//   DEC                 manual one-second decrement, STOP state only
//   LD_MH/LD_ML/LD_SH/LD_SL   preset digits
//   MH/ML/SH/SL         current BCD digits
//   RUN / ALARM         decoded from the registered state
//   ZERO                registered one-cycle pulse on the RUN -> ALARM transition
module timer_down60 #(
    parameter int PRESCALE  = 50000000,
    parameter int ALARM_SEC = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    input  logic       START,
    input  logic       STOP,
    input  logic       DEC,
    input  logic [2:0] LD_MH,
    input  logic [3:0] LD_ML,
    input  logic [2:0] LD_SH,
    input  logic [3:0] LD_SL,
    output logic [2:0] MH,
    output logic [3:0] ML,
    output logic [2:0] SH,
    output logic [3:0] SL,
    output logic       RUN,
    output logic       ALARM,
    output logic       ZERO
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [AW-1:0] ACNT_END  = AW'(ALARM_SEC);
    localparam logic [AW-1:0] ACNT_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_STOP  = 2'd0,
        S_RUN   = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    // Digits packed as {mh[13:11], ml[10:7], sh[6:4], sl[3:0]}.
    logic [13:0]   digits_q, digits_nx, digits_dec;
    logic [PW-1:0] presc_q, presc_nx;
    logic [AW-1:0] acnt_q, acnt_nx;
    state_t        state_q, state_nx;
    logic          zero_q, zero_nx;
    logic          tick;
    logic          at_zero;

    // Clamp a units digit into 0..9.
    function automatic logic [3:0] sat_units(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // Clamp a tens digit into 0..5.
    function automatic logic [2:0] sat_tens(input logic [2:0] v);
        return (v > 3'd5) ? 3'd5 : v;
    endfunction

    // One-second decrement with borrow; 00:00 wraps to 59:59.
    function automatic logic [13:0] dec_time(input logic [13:0] t);
        logic [2:0] mh, sh;
        logic [3:0] ml, sl;
        mh = t[13:11];
        ml = t[10:7];
        sh = t[6:4];
        sl = t[3:0];
        if (sl != 4'd0) begin
            sl = sl - 4'd1;
        end else begin
            sl = 4'd9;
            if (sh != 3'd0) begin
                sh = sh - 3'd1;
            end else begin
                sh = 3'd5;
                if (ml != 4'd0) begin
                    ml = ml - 4'd1;
                end else begin
                    ml = 4'd9;
                    mh = (mh != 3'd0) ? mh - 3'd1 : 3'd5;
                end
            end
        end
        return {mh, ml, sh, sl};
    endfunction

    assign digits_dec = dec_time(digits_q);
    assign tick       = (presc_q == PRESC_MAX);
    assign at_zero    = (digits_q == 14'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_STOP;
            digits_q <= '0;
            presc_q  <= '0;
            acnt_q   <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            digits_q <= digits_nx;
            presc_q  <= presc_nx;
            acnt_q   <= acnt_nx;
            zero_q   <= zero_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        digits_nx = digits_q;
        presc_nx  = presc_q;
        acnt_nx   = acnt_q;
        zero_nx   = 1'b0;

        if (CLR) begin
            digits_nx = {sat_tens(LD_MH), sat_units(LD_ML),
                         sat_tens(LD_SH), sat_units(LD_SL)};
            state_nx  = S_STOP;
            presc_nx  = '0;
            acnt_nx   = '0;
        end else begin
            case (state_q)
                S_STOP: begin
                    // Prescaler idles at zero so RUN always starts with a full second.
                    presc_nx = '0;
                    acnt_nx  = '0;
                    if (!STOP && START && !at_zero) begin
                        state_nx = S_RUN;
                    end else if (DEC) begin
                        digits_nx = digits_dec;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        // Pause: the partial second is discarded.
                        state_nx = S_STOP;
                        presc_nx = '0;
                    end else if (tick) begin
                        presc_nx  = '0;
                        digits_nx = digits_dec;
                        if (digits_dec == 14'd0) begin
                            state_nx = S_ALARM;
                            zero_nx  = 1'b1;
                            acnt_nx  = '0;
                        end
                    end else begin
                        presc_nx = presc_q + PRESC_ONE;
                    end
                end
                S_ALARM: begin
                    if (STOP || START) begin
                        state_nx = S_STOP;
                        presc_nx = '0;
                        acnt_nx  = '0;
                    end else if (tick) begin
                        presc_nx = '0;
                        if ((acnt_q + ACNT_ONE) == ACNT_END) begin
                            state_nx = S_STOP;
                            acnt_nx  = '0;
                        end else begin
                            acnt_nx = acnt_q + ACNT_ONE;
                        end
                    end else begin
                        presc_nx = presc_q + PRESC_ONE;
                    end
                end
                default: begin
                    state_nx = S_STOP;
                    presc_nx = '0;
                    acnt_nx  = '0;
                end
            endcase
        end
    end

    assign MH    = digits_q[13:11];
    assign ML    = digits_q[10:7];
    assign SH    = digits_q[6:4];
    assign SL    = digits_q[3:0];
    assign RUN   = (state_q == S_RUN);
    assign ALARM = (state_q == S_ALARM);
    assign ZERO  = zero_q;

endmodule
